// File: rtl/stack_pipe_pkg.sv
// Shared encodings and record sizing for the barrel-threaded stack.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; one slot serviced per clock).
package stack_pipe_pkg;

  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_RSVD = 2'b10;
  localparam logic [1:0] DELTA_POP  = 2'b11;

  // Bits needed to count 0..DEPTH+1 occupied entries.
  function automatic int depth_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  // Flat per-thread record: {tail, head, depth, ovf, unf}.
  function automatic int state_w(input int width, input int depth);
    return width * (depth + 1) + depth_w(depth) + 2;
  endfunction

  localparam int STATE_W = state_w(16, 18);

endpackage

// File: rtl/stack_lane_next.sv
// Combinational next-state of one thread's stack record (state, we, delta, wd -> state').
// Latency: 0 cycles, purely combinational.
// Backpressure: none; every call produces a result.
module stack_lane_next
  import stack_pipe_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter int          DEPTH = 18,
  parameter logic [15:0] FILL  = 16'h55aa,
  localparam int         DW    = depth_w(DEPTH),
  localparam int         SW    = state_w(WIDTH, DEPTH)
) (
  input  logic [SW-1:0]    state_i,
  input  logic             we_i,
  input  logic [1:0]       delta_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [SW-1:0]    state_o
);

  localparam int               HEAD_LSB = DW + 2;
  localparam int               TAIL_LSB = HEAD_LSB + WIDTH;
  localparam logic [DW-1:0]    FULL     = DW'(DEPTH + 1);
  localparam logic [WIDTH-1:0] FILL_W   = WIDTH'(FILL);

  logic [WIDTH-1:0] tail   [DEPTH];
  logic [WIDTH-1:0] tail_d [DEPTH];
  logic [WIDTH-1:0] head, head_d;
  logic [DW-1:0]    dep, dep_d;
  logic             ovf, ovf_d, unf, unf_d;

  // Split the flat record into its fields; tail[0] sits just above the head.
  always_comb begin
    unf  = state_i[0];
    ovf  = state_i[1];
    dep  = state_i[2 +: DW];
    head = state_i[HEAD_LSB +: WIDTH];
    for (int i = 0; i < DEPTH; i++) tail[i] = state_i[TAIL_LSB + i*WIDTH +: WIDTH];
  end

  // Apply push/pop/hold; a write always overrides the new head, depth saturates and sets flags.
  always_comb begin
    tail_d = tail;
    head_d = we_i ? wd_i : head;
    dep_d  = dep;
    ovf_d  = ovf;
    unf_d  = unf;
    case (delta_i)
      DELTA_PUSH: begin
        tail_d[0] = head;
        for (int i = 1; i < DEPTH; i++) tail_d[i] = tail[i-1];
        if (dep == FULL) ovf_d = 1'b1;
        else             dep_d = dep + DW'(1);
      end
      DELTA_POP: begin
        for (int i = 0; i < DEPTH - 1; i++) tail_d[i] = tail[i+1];
        tail_d[DEPTH-1] = FILL_W;
        if (!we_i) head_d = tail[0];
        if (dep == '0) unf_d = 1'b1;
        else           dep_d = dep - DW'(1);
      end
      DELTA_HOLD, DELTA_RSVD: ;
    endcase
  end

  // Reassemble the record in the same field order.
  always_comb begin
    state_o                     = '0;
    state_o[0]                  = unf_d;
    state_o[1]                  = ovf_d;
    state_o[2 +: DW]            = dep_d;
    state_o[HEAD_LSB +: WIDTH]  = head_d;
    for (int i = 0; i < DEPTH; i++) state_o[TAIL_LSB + i*WIDTH +: WIDTH] = tail_d[i];
  end

endmodule

// File: rtl/stack_pipe_mt.sv
// THREADS interleaved stacks sharing one lane; slots serviced round-robin, one per clock.
// Latency: a slot's update is visible on rd/depth/ovf/unf exactly THREADS cycles later.
// Backpressure: none; every slot accepts an op each turn, overflow/underflow are flagged.
module stack_pipe_mt
  import stack_pipe_pkg::*;
#(
  parameter int          WIDTH   = 16,
  parameter int          DEPTH   = 18,
  parameter int          THREADS = 4,
  parameter logic [15:0] FILL    = 16'h55aa,
  localparam int         TB      = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int         DW      = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       delta,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic [TB-1:0]    slot,
  output logic [DW-1:0]    depth,
  output logic             ovf,
  output logic             unf
);

  localparam int SW       = state_w(WIDTH, DEPTH);
  localparam int HEAD_LSB = DW + 2;

  logic [SW-1:0] ring_q [THREADS];
  logic [SW-1:0] ring_d;
  logic [SW-1:0] cur;
  logic [TB-1:0] slot_q, slot_d;
  logic [DW-1:0] depth_mirror;

  // The last ring stage holds the record of the slot being serviced now.
  assign cur = ring_q[THREADS-1];

  stack_lane_next #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) u_lane (
    .state_i (cur),
    .we_i    (we),
    .delta_i (delta),
    .wd_i    (wd),
    .state_o (ring_d)
  );

  // Round-robin slot counter, wrapping at THREADS-1 for any thread count.
  always_comb slot_d = (slot_q == TB'(THREADS - 1)) ? '0 : slot_q + TB'(1);

  // Slot register; reset restarts the rotation at slot 0.
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  // Ring: the updated record enters stage 0 and returns to the output stage THREADS cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < THREADS; i++) ring_q[i] <= '0;
    end else begin
      ring_q[0] <= ring_d;
      for (int i = 1; i < THREADS; i++) ring_q[i] <= ring_q[i-1];
    end
  end

  // Depth kept on its own named net so simulation monitors can probe it.
  assign depth_mirror = cur[2 +: DW];

  assign rd    = cur[HEAD_LSB +: WIDTH];
  assign depth = depth_mirror;
  assign ovf   = cur[1];
  assign unf   = cur[0];
  assign slot  = slot_q;

endmodule

// File: tb/tb_stack_pipe_mt.sv
// Bench for stack_pipe_mt: directed table, overflow sequence and randomized parameter sweep.
// Latency: checks outputs each cycle at negedge against a queue-based reference model.
// Backpressure: n/a.
module tb_stack_pipe_mt;

  localparam int NI = 5;   // DUT instances
  localparam int NT = 5;   // max threads per instance in the model arrays

  // Instance configurations: 0 default, 1 shallow for overflow, 2..4 sweep.
  function automatic int cfg_t(input int k);
    case (k) 0: return 4; 1: return 4; 2: return 1; 3: return 3; default: return 5; endcase
  endfunction
  function automatic int cfg_w(input int k);
    case (k) 0: return 16; 1: return 16; 2: return 8; 3: return 32; default: return 8; endcase
  endfunction
  function automatic int cfg_d(input int k);
    case (k) 0: return 18; 1: return 2; 2: return 3; 3: return 2; default: return 4; endcase
  endfunction
  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a    [NI];
  logic [1:0]  delta_a [NI];
  logic [31:0] wd_a    [NI];
  logic [31:0] rd_a    [NI];
  logic [31:0] slot_a  [NI];
  logic [31:0] dep_a   [NI];
  logic        ovf_a   [NI];
  logic        unf_a   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GT  = cfg_t(g);
    localparam int GW  = cfg_w(g);
    localparam int GD  = cfg_d(g);
    localparam int GTB = (GT > 1) ? $clog2(GT) : 1;
    localparam int GDW = $clog2(GD + 2);
    logic [GW-1:0]  rd_w;
    logic [GTB-1:0] slot_w;
    logic [GDW-1:0] dep_w;
    logic           ovf_w, unf_w;
    stack_pipe_mt #(.WIDTH(GW), .DEPTH(GD), .THREADS(GT), .FILL(16'h55aa)) u_dut (
      .clk(clk), .reset(reset), .we(we_a[g]), .delta(delta_a[g]), .wd(wd_a[g][GW-1:0]),
      .rd(rd_w), .slot(slot_w), .depth(dep_w), .ovf(ovf_w), .unf(unf_w)
    );
    assign rd_a[g]   = 32'(rd_w);
    assign slot_a[g] = 32'(slot_w);
    assign dep_a[g]  = 32'(dep_w);
    assign ovf_a[g]  = ovf_w;
    assign unf_a[g]  = unf_w;
  end

  // Reference model: each stack is a queue of DEPTH+1 entries, index 0 = head.
  logic [31:0] mq [NI*NT][$];
  int          mdep  [NI*NT];
  logic        movf  [NI*NT];
  logic        munf  [NI*NT];
  int          mslot [NI];

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mslot[k] = 0;
      for (int t = 0; t < NT; t++) begin
        mq[k*NT+t].delete();
        for (int d = 0; d <= cfg_d(k); d++) mq[k*NT+t].push_back(32'h0);
        mdep[k*NT+t] = 0;
        movf[k*NT+t] = 1'b0;
        munf[k*NT+t] = 1'b0;
      end
    end
  endtask

  task automatic model_update(input int k);
    int t, i;
    logic [31:0] m, w, top;
    t = mslot[k];
    i = k*NT + t;
    m = mask_of(cfg_w(k));
    w = wd_a[k] & m;
    case (delta_a[k])
      2'b01: begin
        top = we_a[k] ? w : mq[i][0];
        mq[i].push_front(top);
        void'(mq[i].pop_back());
        if (mdep[i] == cfg_d(k) + 1) movf[i] = 1'b1;
        else                         mdep[i]++;
      end
      2'b11: begin
        void'(mq[i].pop_front());
        mq[i].push_back(32'h55aa & m);
        if (we_a[k]) mq[i][0] = w;
        if (mdep[i] == 0) munf[i] = 1'b1;
        else              mdep[i]--;
      end
      default: if (we_a[k]) mq[i][0] = w;
    endcase
    mslot[k] = (t + 1) % cfg_t(k);
  endtask

  // Compare every instance's outputs with the model at negedge.
  task automatic sample();
    int i;
    @(negedge clk);
    if (check_en) begin
      for (int k = 0; k < NI; k++) begin
        i = k*NT + mslot[k];
        chk("rd",    k, rd_a[k],   mq[i][0]);
        chk("depth", k, dep_a[k],  32'(mdep[i]));
        chk("ovf",   k, 32'(ovf_a[k]), 32'(movf[i]));
        chk("unf",   k, 32'(unf_a[k]), 32'(munf[i]));
        chk("slot",  k, slot_a[k], 32'(mslot[k]));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) model_reset();
    else for (int k = 0; k < NI; k++) model_update(k);
    #1;
  endtask

  task automatic hold_all();
    for (int k = 0; k < NI; k++) begin
      we_a[k] = 1'b0; delta_a[k] = 2'b00; wd_a[k] = 32'h0;
    end
  endtask

  // One operation on instance 1 at slot s, with explicit expected outputs before it applies.
  task automatic turn1(input int s, input logic we, input logic [1:0] dl, input logic [31:0] wd,
                       input logic [31:0] e_rd, input int e_dep, input logic e_ovf, input logic e_unf);
    int n;
    n = 0;
    hold_all();
    while (mslot[1] != s && n < 8) begin
      sample(); advance(); n++;
    end
    if (mslot[1] != s) chk("turn_timeout", 1, 32'(mslot[1]), 32'(s));
    we_a[1] = we; delta_a[1] = dl; wd_a[1] = wd;
    sample();
    chk("ovr_rd",  1, rd_a[1], e_rd);
    chk("ovr_dep", 1, dep_a[1], 32'(e_dep));
    chk("ovr_ovf", 1, 32'(ovf_a[1]), 32'(e_ovf));
    chk("ovr_unf", 1, 32'(unf_a[1]), 32'(e_unf));
    advance();
    hold_all();
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  delta;
    logic [15:0] wd;
    logic [15:0] rd;
    int          dep;
    logic        ovf;
    logic        unf;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] dl, input logic [15:0] wd,
                              input logic [15:0] rd, input int dep, input logic ovf, input logic unf);
    vec_t v;
    v.we = we; v.delta = dl; v.wd = wd; v.rd = rd; v.dep = dep; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  vec_t tbl [29];

  initial begin
    int r;
    bit push_bias;

    // Directed table for instance 0 (4 threads): row c runs on slot c%4.
    for (int c = 0; c < 29; c++) tbl[c] = mk(1'b0, 2'b00, 16'h0, 16'h0, 0, 1'b0, 1'b0);
    tbl[0]  = mk(1'b1, 2'b01, 16'h1111, 16'h0000, 0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 2'b01, 16'h2222, 16'h0000, 0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 2'b01, 16'h0002, 16'h1111, 1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 2'b11, 16'h0000, 16'h2222, 1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 2'b01, 16'h0003, 16'h0002, 2, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 2'b11, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 2'b11, 16'h0000, 16'h0003, 3, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 2'b11, 16'h00ff, 16'h0002, 2, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 2'b10, 16'habcd, 16'h0000, 0, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 2'b11, 16'h0000, 16'h00ff, 1, 1'b0, 1'b0);
    tbl[21] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 1'b1);
    tbl[24] = mk(1'b0, 2'b11, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 1'b1);
    tbl[28] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, 0, 1'b0, 1'b1);

    // Reset with a push+write pending: reset must win.
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      we_a[k] = 1'b1; delta_a[k] = 2'b01; wd_a[k] = 32'hbeef_beef;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_en = 1'b1;
    sample();
    chk("rst_rd",   0, rd_a[0], 32'h0);
    chk("rst_dep",  0, dep_a[0], 32'h0);
    chk("rst_ovf",  0, 32'(ovf_a[0]), 32'h0);
    chk("rst_unf",  0, 32'(unf_a[0]), 32'h0);
    chk("rst_slot", 0, slot_a[0], 32'h0);
    advance();
    reset = 1'b0;
    hold_all();

    for (int c = 0; c < 29; c++) begin
      we_a[0] = tbl[c].we; delta_a[0] = tbl[c].delta; wd_a[0] = 32'(tbl[c].wd);
      sample();
      chk("tbl_rd",   0, rd_a[0], 32'(tbl[c].rd));
      chk("tbl_dep",  0, dep_a[0], 32'(tbl[c].dep));
      chk("tbl_ovf",  0, 32'(ovf_a[0]), 32'(tbl[c].ovf));
      chk("tbl_unf",  0, 32'(unf_a[0]), 32'(tbl[c].unf));
      chk("tbl_slot", 0, slot_a[0], 32'(c % 4));
      advance();
    end
    hold_all();

    // Overflow on instance 1 (DEPTH=2), slot 2: A is pushed off the bottom.
    turn1(2, 1'b1, 2'b01, 32'h000a, 32'h0000, 0, 1'b0, 1'b0);
    turn1(2, 1'b1, 2'b01, 32'h000b, 32'h000a, 1, 1'b0, 1'b0);
    turn1(2, 1'b1, 2'b01, 32'h000c, 32'h000b, 2, 1'b0, 1'b0);
    turn1(2, 1'b1, 2'b01, 32'h000d, 32'h000c, 3, 1'b0, 1'b0);
    turn1(2, 1'b0, 2'b11, 32'h0000, 32'h000d, 3, 1'b1, 1'b0);
    turn1(2, 1'b0, 2'b11, 32'h0000, 32'h000c, 2, 1'b1, 1'b0);
    turn1(2, 1'b0, 2'b11, 32'h0000, 32'h000b, 1, 1'b1, 1'b0);
    turn1(2, 1'b0, 2'b11, 32'h0000, 32'h55aa, 0, 1'b1, 1'b0);
    turn1(2, 1'b0, 2'b00, 32'h0000, 32'h55aa, 0, 1'b1, 1'b1);
    turn1(3, 1'b0, 2'b00, 32'h0000, 32'h0000, 0, 1'b0, 1'b0);

    // Randomized sweep with resets injected mid-rotation.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = (cyc == 777 || cyc == 1501 || $urandom_range(0, 299) == 0);
      push_bias = ((cyc / 150) % 2) == 0;
      for (int k = 0; k < NI; k++) begin
        r = $urandom_range(0, 9);
        we_a[k] = $urandom_range(0, 1) == 1;
        wd_a[k] = $urandom;
        if (r < 6)      delta_a[k] = push_bias ? 2'b01 : 2'b11;
        else if (r < 8) delta_a[k] = push_bias ? 2'b11 : 2'b01;
        else if (r < 9) delta_a[k] = 2'b00;
        else            delta_a[k] = 2'b10;
      end
      sample();
      advance();
    end
    reset = 1'b0;
    hold_all();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
